ahb_master: RTL and testbench

Single-master AHB-Lite bus front end that turns a core-side load/store request stream into AHB address/data phases and drives the `haddr`/`htrans`/`hwrite`/`hsize`/`hprot`/`hwdata`/`is_signed` inputs of `ahb_interconnect`. It consumes that block's muxed `hr_data`/`hready`/`hresp` and returns one response per request.
- Supports one address phase overlapped with one data phase: back-to-back NONSEQ single transfers.
- Performs write-lane replication, read-lane extraction and sign/zero extension.
- Faults misaligned or illegal-size requests locally; they never reach the bus.

---
 rtl/ahb_master.sv | 137 +++++++++++++
 tb/tb_ahb_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master.sv
// AHB-Lite single-master front end: core load/store requests in, one address
// phase overlapped with one data phase, one response per request out.
module ahb_master (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_write,
   input  logic [2:0]  req_size,
   input  logic [3:0]  req_prot,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] haddr,
   output logic [1:0]  htrans,
   output logic        hwrite,
   output logic [2:0]  hsize,
   output logic [3:0]  hprot,
   output logic        is_signed,
   output logic [31:0] hwdata,
   input  logic [31:0] hr_data,
   input  logic        hready,
   input  logic        hresp
);

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_e;

   logic        dp_valid_q,  dp_valid_d;
   logic        dp_fault_q,  dp_fault_d;
   logic        dp_write_q,  dp_write_d;
   logic [2:0]  dp_size_q,   dp_size_d;
   logic [1:0]  dp_lo_q,     dp_lo_d;
   logic        dp_signed_q, dp_signed_d;
   logic [31:0] dp_wdata_q,  dp_wdata_d;

   logic        legal;
   logic        cancel;
   logic        accept;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   htrans_e     htrans_e_w;

   always_comb begin
      legal = 1'b0;
      case (req_size)
         3'd0:    legal = 1'b1;
         3'd1:    legal = ~req_addr[0];
         3'd2:    legal = (req_addr[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   // First ERROR cycle: the pending address must not be issued.
   assign cancel    = dp_valid_q & hresp & ~hready;
   assign req_ready = hready & ~cancel;
   assign accept    = req_valid & req_ready;

   assign htrans_e_w = (req_valid && legal && !cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign htrans     = htrans_e_w;
   assign haddr      = req_addr;
   assign hwrite     = req_write;
   assign hsize      = req_size;
   assign hprot      = req_prot;
   assign is_signed  = req_signed;

   always_comb begin
      dp_valid_d  = dp_valid_q;
      dp_fault_d  = dp_fault_q;
      dp_write_d  = dp_write_q;
      dp_size_d   = dp_size_q;
      dp_lo_d     = dp_lo_q;
      dp_signed_d = dp_signed_q;
      dp_wdata_d  = dp_wdata_q;
      if (hready) begin
         if (accept) begin
            dp_valid_d  = 1'b1;
            dp_fault_d  = ~legal;
            dp_write_d  = req_write;
            dp_size_d   = req_size;
            dp_lo_d     = req_addr[1:0];
            dp_signed_d = req_signed;
            dp_wdata_d  = req_wdata;
         end else begin
            dp_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) dp_valid_q <= 1'b0;
      else       dp_valid_q <= dp_valid_d;
   end

   always_ff @(posedge clk) begin
      dp_fault_q  <= dp_fault_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      dp_lo_q     <= dp_lo_d;
      dp_signed_q <= dp_signed_d;
      dp_wdata_q  <= dp_wdata_d;
   end

   always_comb begin
      hwdata = '0;
      if (dp_valid_q && dp_write_q) begin
         case (dp_size_q)
            3'd0:    hwdata = {4{dp_wdata_q[7:0]}};
            3'd1:    hwdata = {2{dp_wdata_q[15:0]}};
            default: hwdata = dp_wdata_q;
         endcase
      end
   end

   assign rd_byte = hr_data[{dp_lo_q, 3'b000} +: 8];
   assign rd_half = hr_data[{dp_lo_q[1], 4'b0000} +: 16];

   assign rsp_valid = dp_valid_q & hready;
   assign rsp_err   = rsp_valid & (dp_fault_q | hresp);

   always_comb begin
      rsp_rdata = '0;
      if (rsp_valid && !dp_fault_q && !hresp && !dp_write_q) begin
         case (dp_size_q)
            3'd0:    rsp_rdata = {{24{dp_signed_q & rd_byte[7]}}, rd_byte};
            3'd1:    rsp_rdata = {{16{dp_signed_q & rd_half[15]}}, rd_half};
            default: rsp_rdata = hr_data;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: directed scenarios with literal expectations, then
// randomized requester/slave traffic checked against a behavioural model.
module tb_ahb_master;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [2:0]  req_size;
   logic [3:0]  req_prot;
   logic        req_signed;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic        is_signed;
   logic [31:0] hwdata;
   logic [31:0] hr_data;
   logic        hready;
   logic        hresp;

   ahb_master dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_size(req_size), .req_prot(req_prot),
      .req_signed(req_signed), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hprot(hprot), .is_signed(is_signed), .hwdata(hwdata),
      .hr_data(hr_data), .hready(hready), .hresp(hresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_rsp = 0;

   // Model: the single outstanding data-phase transfer.
   logic        m_pv = 1'b0;
   logic        m_pfault, m_pwrite, m_psigned;
   logic [2:0]  m_psize;
   logic [1:0]  m_plo;
   logic [31:0] m_pwdata;

   // Random slave and requester state.
   int          sl_wait = 0;
   bit          sl_err = 0;
   bit          sl_e1 = 0;
   bit          hold = 0;

   // Samples taken at the checking point of the last step.
   logic [1:0]  s_htrans;
   logic        s_req_ready, s_rsp_valid, s_rsp_err;
   logic [31:0] s_rsp_rdata, s_hwdata, s_haddr;

   function automatic logic is_legal(input logic [31:0] a, input logic [2:0] s);
      return (s == 3'd0) || (s == 3'd1 && a[0] == 1'b0) || (s == 3'd2 && a[1:0] == 2'b00);
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] d, input logic [2:0] s,
                                           input logic [1:0] lo, input logic sg);
      logic [31:0] v;
      v = d >> (8 * lo);
      if (s == 3'd0) begin
         v = v & 32'h0000_00FF;
         if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (s == 3'd1) begin
         v = v & 32'h0000_FFFF;
         if (sg && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] replicate(input logic [31:0] wd, input logic [2:0] s);
      if (s == 3'd0) return 32'(wd[7:0]) * 32'h0101_0101;
      if (s == 3'd1) return 32'(wd[15:0]) * 32'h0001_0001;
      return wd;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic req(input logic v, input logic [31:0] a, input logic w,
                      input logic [2:0] s, input logic sg, input logic [31:0] wd);
      req_valid = v; req_addr = a; req_write = w; req_size = s;
      req_signed = sg; req_wdata = wd; req_prot = 4'($urandom);
   endtask

   task automatic slv(input logic rdy, input logic rsp, input logic [31:0] d);
      hready = rdy; hresp = rsp; hr_data = d;
   endtask

   // One clock: check combinational outputs mid-cycle, then advance the model.
   task automatic step(input bit do_chk);
      logic        e_cancel, e_ready, e_rv, e_err;
      logic [1:0]  e_ht;
      logic [31:0] e_rd;
      #4;
      e_cancel = m_pv && hresp && !hready;
      e_ready  = hready && !e_cancel;
      e_ht     = (req_valid && is_legal(req_addr, req_size) && !e_cancel) ? 2'b10 : 2'b00;
      e_rv     = m_pv && hready;
      e_err    = e_rv && (m_pfault || hresp);
      e_rd     = (e_rv && !m_pfault && !hresp && !m_pwrite)
                 ? extract(hr_data, m_psize, m_plo, m_psigned) : 32'h0;
      s_htrans = htrans; s_req_ready = req_ready; s_rsp_valid = rsp_valid;
      s_rsp_err = rsp_err; s_rsp_rdata = rsp_rdata; s_hwdata = hwdata; s_haddr = haddr;
      if (rsp_valid === 1'b1) n_rsp++;
      if (do_chk) begin
         chk("htrans", 32'(htrans), 32'(e_ht));
         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("addr_phase", {haddr[27:0], hwrite, hsize},
             {req_addr[27:0], req_write, req_size});
         chk("prot_signed", {27'h0, hprot, is_signed}, {27'h0, req_prot, req_signed});
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         chk("rsp_err", 32'(rsp_err), 32'(e_err));
         chk("rsp_rdata", rsp_rdata, e_rd);
         if (!(m_pv && m_pfault))
            chk("hwdata", hwdata, (m_pv && m_pwrite) ? replicate(m_pwdata, m_psize) : 32'h0);
      end
      @(posedge clk);
      if (!hready) begin
         if (sl_wait > 0) sl_wait--;
         else sl_e1 = 1;
      end
      hold = req_valid && !(e_ready && !reset);
      if (reset) begin
         m_pv = 1'b0;
         hold = 0;
      end else if (hready) begin
         if (req_valid && e_ready) begin
            m_pv = 1'b1; m_pfault = !is_legal(req_addr, req_size);
            m_pwrite = req_write; m_psize = req_size; m_plo = req_addr[1:0];
            m_psigned = req_signed; m_pwdata = req_wdata;
            sl_wait = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 2));
            sl_err = ($urandom % 8 == 0);
            sl_e1 = 0;
         end else begin
            m_pv = 1'b0;
         end
      end
      #1;
   endtask

   task automatic rand_slave();
      hr_data = $urandom;
      if (m_pv && !m_pfault) begin
         if (sl_wait > 0)       begin hready = 1'b0; hresp = 1'b0; end
         else if (sl_err && !sl_e1) begin hready = 1'b0; hresp = 1'b1; end
         else if (sl_err)       begin hready = 1'b1; hresp = 1'b1; end
         else                   begin hready = 1'b1; hresp = 1'b0; end
      end else begin
         hready = 1'b1; hresp = 1'b0;
      end
   endtask

   task automatic rand_req();
      int r;
      logic [31:0] a;
      logic [2:0]  s;
      if (hold) return;
      r = int'($urandom % 16);
      s = (r < 5) ? 3'd0 : (r < 10) ? 3'd1 : (r < 15) ? 3'd2 : 3'(4 + $urandom % 4 == 4 ? 3 : 3 + $urandom % 5);
      a = $urandom;
      if ($urandom % 4 != 0) begin
         if (s == 3'd1) a[0] = 1'b0;
         if (s == 3'd2) a[1:0] = 2'b00;
      end
      req($urandom % 4 != 0, a, 1'($urandom), s, 1'($urandom), $urandom);
   endtask

   initial begin
      int n0;
      // Reset with no request; first cycle's register contents are unknown.
      reset = 1'b1;
      req(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
      slv(1'b0, 1'b0, 32'h0);
      step(0);
      step(1);
      chk("reset_htrans", 32'(s_htrans), 32'h0);
      chk("reset_rsp_valid", 32'(s_rsp_valid), 32'h0);
      chk("reset_hwdata", s_hwdata, 32'h0);
      reset = 1'b0;
      slv(1'b1, 1'b0, 32'h0);
      step(1);
      chk("reset_req_ready", 32'(s_req_ready), 32'h1);

      // Word read, zero wait.
      req(1'b1, 32'h1000_0000, 1'b0, 3'd2, 1'b0, 32'h0);
      step(1);
      chk("wr_nonseq", 32'(s_htrans), 32'h2);
      req(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
      slv(1'b1, 1'b0, 32'hDEAD_BEEF);
      step(1);
      chk("wr_rsp_valid", 32'(s_rsp_valid), 32'h1);
      chk("wr_rdata", s_rsp_rdata, 32'hDEAD_BEEF);
      chk("wr_err", 32'(s_rsp_err), 32'h0);

      // Byte read at lane 3 with two wait states, signed then unsigned.
      for (int k = 0; k < 2; k++) begin
         req(1'b1, 32'h1000_0003, 1'b0, 3'd0, (k == 0), 32'h0);
         slv(1'b1, 1'b0, 32'h0);
         step(1);
         req(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
         slv(1'b0, 1'b0, 32'h0);
         step(1);
         step(1);
         chk("byte_wait_no_rsp", 32'(s_rsp_valid), 32'h0);
         slv(1'b1, 1'b0, 32'h8012_3456);
         step(1);
         chk("byte_rsp_valid", 32'(s_rsp_valid), 32'h1);
         chk("byte_rdata", s_rsp_rdata, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      end

      // Half write followed back-to-back by a word read.
      req(1'b1, 32'h2000_0002, 1'b1, 3'd1, 1'b0, 32'h0000_1234);
      slv(1'b1, 1'b0, 32'h0);
      step(1);
      n0 = n_rsp;
      req(1'b1, 32'h2000_0004, 1'b0, 3'd2, 1'b0, 32'h0);
      step(1);
      chk("bb_hwdata", s_hwdata, 32'h1234_1234);
      chk("bb_haddr", s_haddr, 32'h2000_0004);
      chk("bb_htrans", 32'(s_htrans), 32'h2);
      chk("bb_wr_rdata", s_rsp_rdata, 32'h0);
      req(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
      slv(1'b1, 1'b0, 32'hCAFE_F00D);
      step(1);
      chk("bb_rd_rdata", s_rsp_rdata, 32'hCAFE_F00D);
      step(1);
      chk("bb_rsp_count", 32'(n_rsp - n0), 32'd2);

      // Slave ERROR with the next request pending.
      req(1'b1, 32'h4000_0000, 1'b0, 3'd2, 1'b0, 32'h0);
      step(1);
      req(1'b1, 32'h4000_0008, 1'b0, 3'd2, 1'b0, 32'h0);
      slv(1'b0, 1'b1, 32'h0);
      step(1);
      chk("e1_htrans", 32'(s_htrans), 32'h0);
      chk("e1_req_ready", 32'(s_req_ready), 32'h0);
      slv(1'b1, 1'b1, 32'h0);
      step(1);
      chk("e2_rsp_err", 32'(s_rsp_err), 32'h1);
      chk("e2_htrans", 32'(s_htrans), 32'h2);
      req(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
      slv(1'b1, 1'b0, 32'h1122_3344);
      step(1);
      chk("e_next_rdata", s_rsp_rdata, 32'h1122_3344);

      // Local faults: misaligned word, then illegal size.
      req(1'b1, 32'h5000_0002, 1'b0, 3'd2, 1'b0, 32'h0);
      slv(1'b1, 1'b0, 32'h0);
      step(1);
      chk("mis_htrans", 32'(s_htrans), 32'h0);
      req(1'b1, 32'h5000_0000, 1'b0, 3'd3, 1'b0, 32'h0);
      step(1);
      chk("sz3_htrans", 32'(s_htrans), 32'h0);
      chk("mis_rsp", {s_rsp_rdata[29:0], s_rsp_valid, s_rsp_err}, 32'h3);
      req(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
      slv(1'b1, 1'b0, 32'hFFFF_FFFF);
      step(1);
      chk("sz3_rsp", {s_rsp_rdata[29:0], s_rsp_valid, s_rsp_err}, 32'h3);

      // Reset while a data phase is outstanding drops it silently.
      req(1'b1, 32'h6000_0000, 1'b0, 3'd2, 1'b0, 32'h0);
      step(1);
      req(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
      reset = 1'b1;
      slv(1'b0, 1'b0, 32'h0);
      step(1);
      reset = 1'b0;
      slv(1'b1, 1'b0, 32'h1234_5678);
      step(1);
      chk("rst_drop_rsp", 32'(s_rsp_valid), 32'h0);

      // Randomized traffic.
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom % 200 == 0);
         rand_req();
         rand_slave();
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
